// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: a single full-adder slice and a carry register
// process one operand bit per clock, LSB first, behind a start/busy/done handshake.
module serial_add_sub #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             Cin0,
    input  logic             subtract,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             C1,
    output logic             overflow
);
    // state | meaning
    // IDLE  | waiting for start
    // RUN   | one operand bit per edge, WIDTH edges
    // DONE  | result valid for one cycle; start here is accepted back-to-back
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             c1_q, c1_d;
    logic             ovf_q, ovf_d;
    logic             bit_s;
    logic             carry_nx;

    assign bit_s    = a_q[0] ^ b_q[0] ^ carry_q;
    assign carry_nx = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        c1_d    = c1_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    // Subtract as A + ~B + 1 - Cin0: invert B, seed carry with !Cin0.
                    state_d = S_RUN;
                    a_d     = a;
                    b_d     = subtract ? ~b : b;
                    carry_d = Cin0 ^ subtract;
                    cnt_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                res_d   = {bit_s, res_q[WIDTH-1:1]};
                carry_d = carry_nx;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    // carry_q here is the carry into the MSB
                    state_d = S_DONE;
                    sum_d   = res_d;
                    c1_d    = carry_nx;
                    ovf_d   = carry_q ^ carry_nx;
                    cnt_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            c1_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            c1_q    <= c1_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy     = (state_q == S_RUN);
    assign done     = (state_q == S_DONE);
    assign sum      = sum_q;
    assign C1       = c1_q;
    assign overflow = ovf_q;
endmodule

// File: tb/tb_serial_add_sub.sv
// Directed-vector and random bench for serial_add_sub at WIDTH=4.
module tb_serial_add_sub;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset, start, Cin0, subtract;
    logic [W-1:0] a, b;
    logic         busy, done, C1, overflow;
    logic [W-1:0] sum;

    int           n_cmp = 0;
    int           n_err = 0;
    logic [W-1:0] prev_sum;

    typedef struct {
        string        name;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] s;
        logic         c1;
        logic         ov;
    } vec_t;

    vec_t vt[7];

    serial_add_sub #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
        .Cin0(Cin0), .subtract(subtract), .busy(busy), .done(done),
        .sum(sum), .C1(C1), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Independent integer model: unsigned result for sum/C1, signed range for overflow.
    function automatic void model(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                  input logic cin, input logic sub,
                                  output logic [W-1:0] s, output logic c1, output logic ov);
        int ua, ub, sa, sb, r, sr;
        ua = int'(ia);
        ub = int'(ib);
        sa = ia[W-1] ? ua - 16 : ua;
        sb = ib[W-1] ? ub - 16 : ub;
        if (!sub) begin
            r  = ua + ub + int'(cin);
            sr = sa + sb + int'(cin);
            c1 = (r >= 16);
        end else begin
            r  = ua - ub - int'(cin);
            sr = sa - sb - int'(cin);
            c1 = (r >= 0);
        end
        s  = W'(r & 15);
        ov = (sr < -8) || (sr > 7);
    endfunction

    // Called at a negedge; returns at the negedge where done is seen.
    task automatic run_op(input string nm, input logic [W-1:0] ia, input logic [W-1:0] ib,
                          input logic cin, input logic sub,
                          input logic [W-1:0] es, input logic ec1, input logic eov);
        int done_at, busy_cnt, overlap;
        done_at = 0; busy_cnt = 0; overlap = 0;
        start = 1'b1; a = ia; b = ib; Cin0 = cin; subtract = sub;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) begin
                chk({nm, " held_sum"}, int'(sum), int'(prev_sum));
                start = 1'b0;
                a = W'($urandom); b = W'($urandom);
                Cin0 = 1'($urandom); subtract = 1'($urandom);
            end
            if (busy && done) overlap++;
            if (busy) busy_cnt++;
            if (done) begin
                done_at = k;
                break;
            end
        end
        chk({nm, " latency"}, done_at, 5);
        chk({nm, " busy_cycles"}, busy_cnt, 4);
        chk({nm, " busy_done_overlap"}, overlap, 0);
        chk({nm, " sum"}, int'(sum), int'(es));
        chk({nm, " C1"}, int'(C1), int'(ec1));
        chk({nm, " overflow"}, int'(overflow), int'(eov));
        prev_sum = es;
    endtask

    initial begin
        logic [W-1:0] ha[26], hb[26];
        logic         hc[26], hs[26];
        logic [W-1:0] es;
        logic         ec1, eov;
        int           dn;

        vt[0] = '{"add_ovf",   4'b0011, 4'b0101, 1'b0, 1'b0, 4'b1000, 1'b0, 1'b1};
        vt[1] = '{"add_wrap",  4'b1111, 4'b0001, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0};
        vt[2] = '{"add_cin",   4'b1111, 4'b1111, 1'b1, 1'b0, 4'b1111, 1'b1, 1'b0};
        vt[3] = '{"sub_pos",   4'b0110, 4'b0001, 1'b0, 1'b1, 4'b0101, 1'b1, 1'b0};
        vt[4] = '{"sub_borrow",4'b0010, 4'b0011, 1'b0, 1'b1, 4'b1111, 1'b0, 1'b0};
        vt[5] = '{"sub_ovf",   4'b1000, 4'b0001, 1'b0, 1'b1, 4'b0111, 1'b1, 1'b1};
        vt[6] = '{"sub_bin",   4'b1010, 4'b0001, 1'b1, 1'b1, 4'b1000, 1'b1, 1'b0};

        reset = 1'b1; start = 1'b0; a = '0; b = '0; Cin0 = 1'b0; subtract = 1'b0;
        prev_sum = '0;
        repeat (3) @(negedge clk);
        chk("rst busy", int'(busy), 0);
        chk("rst done", int'(done), 0);
        chk("rst sum", int'(sum), 0);
        chk("rst C1", int'(C1), 0);
        chk("rst overflow", int'(overflow), 0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++)
            run_op(vt[i].name, vt[i].a, vt[i].b, vt[i].cin, vt[i].sub, vt[i].s, vt[i].c1, vt[i].ov);

        // start held high, operands changing every cycle; accepts land every 5 edges
        @(negedge clk);
        for (int j = 0; j <= 25; j++) begin
            if (j > 0) begin
                @(negedge clk);
                chk("hs busy", int'(busy), (j % 5 != 0) ? 1 : 0);
                chk("hs done", int'(done), (j % 5 == 0) ? 1 : 0);
                if (j % 5 == 0) begin
                    model(ha[j-5], hb[j-5], hc[j-5], hs[j-5], es, ec1, eov);
                    chk("hs sum", int'(sum), int'(es));
                    chk("hs C1", int'(C1), int'(ec1));
                    chk("hs overflow", int'(overflow), int'(eov));
                    prev_sum = es;
                end
            end
            if (j < 25) begin
                ha[j] = W'($urandom); hb[j] = W'($urandom);
                hc[j] = 1'($urandom); hs[j] = 1'($urandom);
                start = 1'b1; a = ha[j]; b = hb[j]; Cin0 = hc[j]; subtract = hs[j];
            end else begin
                start = 1'b0;
            end
        end
        @(negedge clk);

        // reset on the second RUN cycle discards the operation
        start = 1'b1; a = 4'b0011; b = 4'b0101; Cin0 = 1'b0; subtract = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst busy", int'(busy), 0);
        chk("mid_rst done", int'(done), 0);
        chk("mid_rst sum", int'(sum), 0);
        chk("mid_rst C1", int'(C1), 0);
        chk("mid_rst overflow", int'(overflow), 0);
        reset = 1'b0;
        dn = 0;
        repeat (10) begin
            @(negedge clk);
            if (done || busy) dn++;
        end
        chk("mid_rst no_activity", dn, 0);
        prev_sum = '0;
        run_op("after_rst", 4'b0011, 4'b0101, 1'b0, 1'b0, 4'b1000, 1'b0, 1'b1);

        // reset and start together: reset wins
        start = 1'b1; reset = 1'b1;
        @(negedge clk);
        start = 1'b0; reset = 1'b0;
        @(negedge clk);
        chk("rst_start busy", int'(busy), 0);
        chk("rst_start sum", int'(sum), 0);
        prev_sum = '0;

        for (int i = 0; i < 1000; i++) begin
            logic [W-1:0] ra, rb;
            logic         rc, rs;
            ra = W'($urandom); rb = W'($urandom);
            rc = 1'($urandom); rs = 1'($urandom);
            model(ra, rb, rc, rs, es, ec1, eov);
            run_op("rand", ra, rb, rc, rs, es, ec1, eov);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
